// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared types and helpers for the seven-segment scan controller.
//   scan_state_t : controller state (IDLE = display blanked, SCAN = rotating)
//   AN_OFF       : anode pattern with every digit dark (anodes are active low)
//   an_onehot()  : active-low one-hot anode pattern for a digit index
// ---------------------------------------------------------------------------
package sseg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Only the selected digit's anode is pulled low.
    function automatic logic [3:0] an_onehot(input logic [1:0] sel);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << sel;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_refresh_tick.sv
// ---------------------------------------------------------------------------
// refresh_tick
// Digit-slot divider. Counts clk cycles while run=1 and raises tick for one
// cycle every REFRESH_DIV cycles. The counter is held at 0 while run=0, so the
// first tick after run rises comes exactly REFRESH_DIV cycles later.
// Ports:
//   clk   in  1  system clock
//   reset in  1  synchronous, active-high reset
//   run   in  1  count enable; 0 clears and holds the counter
//   tick  out 1  high on the last cycle of each slot (cnt == REFRESH_DIV-1)
// ---------------------------------------------------------------------------
module refresh_tick #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl
// Time-multiplexed refresh controller for a 4-digit seven-segment display.
// Rotates digit_sel/an through the four digits, one slot per REFRESH_DIV
// cycles, and snapshots value/mode/sign once per frame (on the 3->0 wrap, or
// when scanning starts) so the segment path never sees a half-updated value.
// Ports:
//   clk          in  1   system clock
//   reset        in  1   synchronous, active-high reset
//   en           in  1   1 = scan display, 0 = blank all digits
//   data_in      in  16  value to display
//   hex_dec_in   in  1   mode for next frame (1 = hex, 0 = decimal)
//   sign_in      in  1   negative flag for next frame
//   data_out     out 16  frame-stable copy of data_in
//   hex_dec_out  out 1   frame-stable mode
//   sign_out     out 1   frame-stable sign
//   digit_sel    out 2   digit currently driven, 0 = rightmost
//   an           out 4   active-low anode enables, one-hot-low while scanning
//   frame_start  out 1   one-cycle pulse on the cycle the snapshot is taken
// Configuration:
//   SSEG_SCAN_BLANK_EN  when defined, leading zero digits are kept dark in hex
//                       mode (digit 0 never, digit 3 not while sign_out=1).
// ---------------------------------------------------------------------------
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        hex_dec_in,
    input  logic        sign_in,
    output logic [15:0] data_out,
    output logic        hex_dec_out,
    output logic        sign_out,
    output logic [1:0]  digit_sel,
    output logic [3:0]  an,
    output logic        frame_start
);

    scan_state_t state;
    scan_state_t state_nxt;

    logic        tick;
    logic [1:0]  sel_nxt;
    logic [3:0]  an_nxt;
    logic        snap;
    logic        light;
    logic [15:0] data_nxt;
    logic        hex_nxt;
    logic        sign_nxt;

    refresh_tick #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_refresh_tick (
        .clk   (clk),
        .reset (reset),
        .run   (en),
        .tick  (tick)
    );

`ifdef SSEG_SCAN_BLANK_EN
    // Returns all-ones (digit dark) when the selected digit is a leading zero.
    // lead_zero[k] means nibbles k..3 are all zero.
    function automatic logic [3:0] blank_mask(input logic [1:0]  sel,
                                              input logic [15:0] d,
                                              input logic        hex,
                                              input logic        sign);
        logic [3:0] lead_zero;
        logic       blank;
        lead_zero[3] = (d[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (d[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (d[7:4] == 4'h0);
        lead_zero[0] = 1'b0;
        blank = hex && lead_zero[sel] && !((sel == 2'd3) && sign);
        return blank ? 4'b1111 : 4'b0000;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // en=0 wins over a same-cycle tick, so SCAN drops straight to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && tick) state_nxt = SCAN;
            SCAN:    if (!en)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs. The snapshot is taken only when
    // scanning starts or the rotation wraps from digit 3 back to digit 0.
    always_comb begin
        sel_nxt = digit_sel;
        an_nxt  = an;
        snap    = 1'b0;
        light   = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt = 2'd0;
                an_nxt  = AN_OFF;
                if (en && tick) begin
                    snap  = 1'b1;
                    light = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    sel_nxt = 2'd0;
                    an_nxt  = AN_OFF;
                end else if (tick) begin
                    sel_nxt = digit_sel + 2'd1;
                    snap    = (digit_sel == 2'd3);
                    light   = 1'b1;
                end
            end
            default: begin
                sel_nxt = 2'd0;
                an_nxt  = AN_OFF;
            end
        endcase

        data_nxt = snap ? data_in    : data_out;
        hex_nxt  = snap ? hex_dec_in : hex_dec_out;
        sign_nxt = snap ? sign_in    : sign_out;

        // Blanking looks at the snapshot the new slot will actually display.
        if (light) begin
`ifdef SSEG_SCAN_BLANK_EN
            an_nxt = an_onehot(sel_nxt) | blank_mask(sel_nxt, data_nxt, hex_nxt, sign_nxt);
`else
            an_nxt = an_onehot(sel_nxt);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel   <= 2'd0;
            an          <= AN_OFF;
            data_out    <= 16'h0000;
            hex_dec_out <= 1'b0;
            sign_out    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            digit_sel   <= sel_nxt;
            an          <= an_nxt;
            data_out    <= data_nxt;
            hex_dec_out <= hex_nxt;
            sign_out    <= sign_nxt;
            frame_start <= snap;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_ctrl
// Directed testbench for sseg_scan_ctrl with REFRESH_DIV=4 (one digit slot
// every 4 cycles, one frame every 16). Expected values are hand-computed.
// Expectations for the blanking scenario follow SSEG_SCAN_BLANK_EN.
// ---------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] data_in;
    logic        hex_dec_in;
    logic        sign_in;
    logic [15:0] data_out;
    logic        hex_dec_out;
    logic        sign_out;
    logic [1:0]  digit_sel;
    logic [3:0]  an;
    logic        frame_start;

    int test_count = 0;
    int fail_count = 0;

`ifdef SSEG_SCAN_BLANK_EN
    localparam logic [3:0] EXP_HEX_SLOT2      = 4'b1111;
    localparam logic [3:0] EXP_HEX_SLOT3      = 4'b1111;
    localparam logic [3:0] EXP_HEX_SIGN_SLOT2 = 4'b1111;
`else
    localparam logic [3:0] EXP_HEX_SLOT2      = 4'b1011;
    localparam logic [3:0] EXP_HEX_SLOT3      = 4'b0111;
    localparam logic [3:0] EXP_HEX_SIGN_SLOT2 = 4'b1011;
`endif

    sseg_scan_ctrl #(
        .REFRESH_DIV (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .data_in     (data_in),
        .hex_dec_in  (hex_dec_in),
        .sign_in     (sign_in),
        .data_out    (data_out),
        .hex_dec_out (hex_dec_out),
        .sign_out    (sign_out),
        .digit_sel   (digit_sel),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic e, input logic [15:0] d,
                                 input logic hex, input logic sign);
        en         = e;
        data_in    = d;
        hex_dec_in = hex;
        sign_in    = sign;
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " an"},          16'(an),          16'hF);
        checkOutput({tag, " digit_sel"},   16'(digit_sel),   16'h0);
        checkOutput({tag, " data_out"},    data_out,         16'h0);
        checkOutput({tag, " hex_dec_out"}, 16'(hex_dec_out), 16'h0);
        checkOutput({tag, " sign_out"},    16'(sign_out),    16'h0);
        checkOutput({tag, " frame_start"}, 16'(frame_start), 16'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // 1: reset held 3 cycles with en=1
        reset = 1'b1;
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
        step(3);
        checkReset("reset");
        reset = 1'b0;

        // 2: first lit digit 4 cycles after reset release, then rotation
        step(3);
        checkOutput("startup an dark", 16'(an), 16'hF);
        checkOutput("startup no fs", 16'(frame_start), 16'h0);
        step(1);
        checkOutput("start an", 16'(an), 16'hE);
        checkOutput("start fs", 16'(frame_start), 16'h1);
        checkOutput("start data", data_out, 16'hBEEF);
        checkOutput("start hex", 16'(hex_dec_out), 16'h1);
        step(1);
        checkOutput("fs one cycle", 16'(frame_start), 16'h0);
        step(3);
        checkOutput("slot1 an", 16'(an), 16'hD);
        checkOutput("slot1 sel", 16'(digit_sel), 16'h1);
        step(4);
        checkOutput("slot2 an", 16'(an), 16'hB);
        step(4);
        checkOutput("slot3 an", 16'(an), 16'h7);
        checkOutput("slot3 no fs", 16'(frame_start), 16'h0);
        step(4);
        checkOutput("wrap an", 16'(an), 16'hE);
        checkOutput("wrap fs", 16'(frame_start), 16'h1);

        // 3: mid-frame data change invisible until the wrap
        step(4);
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
        checkOutput("mid sel1 data", data_out, 16'hBEEF);
        step(4);
        checkOutput("mid sel2 data", data_out, 16'hBEEF);
        step(4);
        checkOutput("mid sel3 data", data_out, 16'hBEEF);
        step(3);
        checkOutput("pre-wrap data", data_out, 16'hBEEF);
        checkOutput("pre-wrap sel", 16'(digit_sel), 16'h3);
        step(1);
        checkOutput("post-wrap data", data_out, 16'h1234);
        checkOutput("post-wrap fs", 16'(frame_start), 16'h1);
        checkOutput("post-wrap sel", 16'(digit_sel), 16'h0);

        // 4: en dropped on a tick cycle (sel=1, counter at its last value)
        step(7);
        applyStimulus(1'b0, 16'h5678, 1'b0, 1'b1);
        step(1);
        checkOutput("disable an", 16'(an), 16'hF);
        checkOutput("disable sel", 16'(digit_sel), 16'h0);
        checkOutput("disable fs", 16'(frame_start), 16'h0);
        checkOutput("disable hold data", data_out, 16'h1234);
        step(5);
        checkOutput("idle an", 16'(an), 16'hF);
        applyStimulus(1'b1, 16'h5678, 1'b0, 1'b1);
        step(3);
        checkOutput("reen dark", 16'(an), 16'hF);
        step(1);
        checkOutput("reen an", 16'(an), 16'hE);
        checkOutput("reen fs", 16'(frame_start), 16'h1);
        checkOutput("reen data", data_out, 16'h5678);
        checkOutput("reen hex", 16'(hex_dec_out), 16'h0);
        checkOutput("reen sign", 16'(sign_out), 16'h1);

        // 5: reset pulsed while digit_sel=2
        step(8);
        checkOutput("pre-reset sel", 16'(digit_sel), 16'h2);
        reset = 1'b1;
        step(1);
        checkReset("midframe reset");
        reset = 1'b0;

        // 6: hex leading-zero blanking on 16'h00A5
        applyStimulus(1'b1, 16'h00A5, 1'b1, 1'b0);
        step(4);
        checkOutput("blank slot0", 16'(an), 16'hE);
        step(4);
        checkOutput("blank slot1", 16'(an), 16'hD);
        step(4);
        checkOutput("blank slot2", 16'(an), 16'(EXP_HEX_SLOT2));
        step(4);
        checkOutput("blank slot3", 16'(an), 16'(EXP_HEX_SLOT3));
        checkOutput("blank sel3", 16'(digit_sel), 16'h3);
        applyStimulus(1'b1, 16'h00A5, 1'b1, 1'b1);
        step(4);
        checkOutput("sign slot0", 16'(an), 16'hE);
        step(8);
        checkOutput("sign slot2", 16'(an), 16'(EXP_HEX_SIGN_SLOT2));
        step(4);
        checkOutput("sign slot3", 16'(an), 16'h7);
        applyStimulus(1'b1, 16'h00A5, 1'b0, 1'b0);
        step(4);
        checkOutput("dec slot0", 16'(an), 16'hE);
        step(4);
        checkOutput("dec slot1", 16'(an), 16'hD);
        step(4);
        checkOutput("dec slot2", 16'(an), 16'hB);
        step(4);
        checkOutput("dec slot3", 16'(an), 16'h7);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
